// File: rtl/ialu_pkg.sv
// ialu_pkg: opcodes, width helpers and small utility functions
// shared by the integer ALU issue arbiter slice.
package ialu_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_MUL = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b011;

   function automatic int opw(int dw);
      return 2 * dw + 5;
   endfunction

   function automatic int resw(int dw);
      return 2 * dw + 6;
   endfunction

   function automatic int clog2(int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic logic is_legal_op(logic [2:0] op);
      return (op == OP_MUL) || (op == OP_ADD);
   endfunction

endpackage

// File: rtl/ialu_issue_arb_if.sv
// ialu_issue_arb_if: request, ALU and response bundle of the
// shared ALU issue arbiter; slave side is the arbiter itself.
interface ialu_issue_arb_if #(
   parameter int DWIDTH = 16,
   parameter int NREQ   = 4
);
   import ialu_pkg::*;

   localparam int OPW = opw(DWIDTH);
   localparam int RW  = resw(DWIDTH);

   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [3*NREQ-1:0]   req_opcode;
   logic [OPW*NREQ-1:0] req_a;
   logic [OPW*NREQ-1:0] req_b;
   logic [2:0]          alu_opcode;
   logic [OPW-1:0]      alu_a;
   logic [OPW-1:0]      alu_b;
   logic [RW-1:0]       alu_y;
   logic [NREQ-1:0]     rsp_valid;
   logic [RW-1:0]       rsp_data;
   logic                rsp_err;
   logic                busy;

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, alu_y,
      output req_ready, alu_opcode, alu_a, alu_b,
      output rsp_valid, rsp_data, rsp_err, busy
   );

   modport master (
      output req_valid, req_opcode, req_a, req_b, alu_y,
      input  req_ready, alu_opcode, alu_a, alu_b,
      input  rsp_valid, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/ialu_issue_arb_rr.sv
// rr_arbiter: round-robin one-hot grant over eligibility bits;
// the pointer moves past the winner only when advance is strobed.
module rr_arbiter
   import ialu_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] elig,
   input  logic            adv,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  ptr
);

   logic [IDW-1:0] win;
   logic           found;

   // First eligible requester at or after the pointer wins
   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && elig[j]) begin
            gnt[j] = 1'b1;
            win    = IDW'(j);
            found  = 1'b1;
         end
      end
   end

   // Pointer steps past the winner on an accepted handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      end
   end

endmodule

// File: rtl/ialu_issue_arb.sv
// ialu_issue_arb: shares one pipelined ALU between NREQ requesters
// with credit-bounded issue and tag-routed results. Option: IALU_ARB_PERF_EN.
module ialu_issue_arb
   import ialu_pkg::*;
#(
   parameter int DWIDTH  = 16,
   parameter int NREQ    = 4,
   parameter int LAT     = 4,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   ialu_issue_arb_if.slave bus
`ifdef IALU_ARB_PERF_EN
   ,
   output logic [31:0] perf_issue,
   output logic [31:0] perf_stall
`endif
);

   localparam int OPW = opw(DWIDTH);
   localparam int IDW = clog2(NREQ);
   localparam int CW  = 3;

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] ret;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  win;
   logic            hs;
   logic            legal;
   logic [2:0]      sel_op;
   logic [OPW-1:0]  sel_a;
   logic [OPW-1:0]  sel_b;
   logic [CW-1:0]   cnt [NREQ];

   logic [LAT:0]    tv;
   logic [LAT:0]    terr;
   logic [IDW-1:0]  tid [LAT+1];

   // Requester may compete only while it holds a free credit
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = rst_n & bus.req_valid[i] &
                   (cnt[i] < CW'(MAX_OUT));
      end
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .elig  (elig),
      .adv   (hs),
      .gnt   (gnt),
      .ptr   (rr_ptr)
   );

   assign bus.req_ready = gnt;
   assign hs            = |gnt;

   // Winner index and its operation
   always_comb begin
      win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) win = IDW'(i);
      end
      sel_op = bus.req_opcode[3*int'(win) +: 3];
      sel_a  = bus.req_a[OPW*int'(win) +: OPW];
      sel_b  = bus.req_b[OPW*int'(win) +: OPW];
      legal  = is_legal_op(sel_op);
   end

   // Which requester retires a result on the coming edge
   always_comb begin
      ret = '0;
      for (int i = 0; i < NREQ; i++) begin
         ret[i] = tv[LAT] && (tid[LAT] == IDW'(i));
      end
   end

   // ALU input registers; illegal ops are issued as a zeroed NOP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_opcode <= OP_NOP;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
      end else if (hs && legal) begin
         bus.alu_opcode <= sel_op;
         bus.alu_a      <= sel_a;
         bus.alu_b      <= sel_b;
      end else if (hs) begin
         bus.alu_opcode <= OP_NOP;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
      end else begin
         bus.alu_opcode <= OP_NOP;
      end
   end

   // Tag pipeline tracks owner and error flag alongside the ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tv   <= '0;
         terr <= '0;
         for (int k = 0; k <= LAT; k++) tid[k] <= '0;
      end else begin
         tv[0]   <= hs;
         terr[0] <= hs & ~legal;
         tid[0]  <= win;
         for (int k = 1; k <= LAT; k++) begin
            tv[k]   <= tv[k-1];
            terr[k] <= terr[k-1];
            tid[k]  <= tid[k-1];
         end
      end
   end

   // Route the ALU result to its owner; data holds when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
      end else if (tv[LAT]) begin
         bus.rsp_valid <= ret;
         bus.rsp_data  <= terr[LAT] ? '0 : bus.alu_y;
         bus.rsp_err   <= terr[LAT];
      end else begin
         bus.rsp_valid <= '0;
      end
   end

   // Credits: take one on issue, return one on retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && !ret[i]) cnt[i] <= cnt[i] + CW'(1);
            else if (!gnt[i] && ret[i]) cnt[i] <= cnt[i] - CW'(1);
         end
      end
   end

   assign bus.busy = (|tv) | (bus.alu_opcode != OP_NOP);

`ifdef IALU_ARB_PERF_EN
   // Saturating counters of legal issues and credit stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue <= '0;
         perf_stall <= '0;
      end else begin
         if (hs && legal && perf_issue != '1)
            perf_issue <= perf_issue + 32'd1;
         if ((|bus.req_valid) && !hs && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ialu_issue_arb.sv
// tb_ialu_issue_arb: scoreboard bench with a behavioural ALU model
// covering issue, arbitration, credits, illegal ops and reset.
module tb_ialu_issue_arb;
   import ialu_pkg::*;

   localparam int DWIDTH  = 16;
   localparam int NREQ    = 4;
   localparam int LAT     = 4;
   localparam int MAX_OUT = 2;
   localparam int OPW     = 2 * DWIDTH + 5;
   localparam int RW      = 2 * DWIDTH + 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ialu_issue_arb_if #(.DWIDTH(DWIDTH), .NREQ(NREQ)) bus ();

`ifdef IALU_ARB_PERF_EN
   logic [31:0] perf_issue;
   logic [31:0] perf_stall;
`endif

   ialu_issue_arb #(
      .DWIDTH  (DWIDTH),
      .NREQ    (NREQ),
      .LAT     (LAT),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IALU_ARB_PERF_EN
      ,
      .perf_issue (perf_issue),
      .perf_stall (perf_stall)
`endif
   );

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic logic [RW-1:0] alu_f(logic [2:0] op,
      logic [OPW-1:0] a, logic [OPW-1:0] b);
      case (op)
         3'b001:  return RW'(a) * RW'(b);
         3'b011:  return RW'(a) + RW'(b);
         default: return {RW{1'b1}};
      endcase
   endfunction

   // ALU model: LAT-cycle pipeline, garbage on NOP
   logic [RW-1:0] apipe [LAT];
   always @(posedge clk) begin
      apipe[0] <= alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
   end
   assign bus.alu_y = apipe[LAT-1];

   typedef struct {
      int            id;
      logic [RW-1:0] data;
      logic          err;
      int            cyc;
   } sb_t;

   sb_t sbq[$];
   sb_t me;
   logic [NREQ-1:0] mhs;
   logic [2:0]      mop;

   // Monitor: push on handshake, pop and compare on response
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rsp_valid != '0) begin
            if (sbq.size() == 0) begin
               check("rsp_unexp", 64'(bus.rsp_valid), 64'd0);
            end else begin
               me = sbq.pop_front();
               check("rsp_id", 64'(bus.rsp_valid),
                     64'(1) << me.id);
               check("rsp_data", 64'(bus.rsp_data), 64'(me.data));
               check("rsp_err", 64'(bus.rsp_err), 64'(me.err));
               check("rsp_lat", 64'(cyc - me.cyc), 64'(LAT + 2));
            end
         end
         mhs = bus.req_valid & bus.req_ready;
         if (bus.req_ready != '0) begin
            check("ready_1hot", 64'($onehot(bus.req_ready)), 64'd1);
            check("ready_sub", 64'(bus.req_ready & ~bus.req_valid),
                  64'd0);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (mhs[i]) begin
               mop     = bus.req_opcode[3*i +: 3];
               me.id   = i;
               me.cyc  = cyc;
               me.err  = !(mop == 3'b001 || mop == 3'b011);
               me.data = me.err ? '0 :
                         alu_f(mop, bus.req_a[OPW*i +: OPW],
                               bus.req_b[OPW*i +: OPW]);
               sbq.push_back(me);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid  = '0;
      bus.req_opcode = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
   endtask

   task automatic set_req(int i, logic [2:0] op,
                          logic [OPW-1:0] a, logic [OPW-1:0] b);
      bus.req_valid[i]           = 1'b1;
      bus.req_opcode[3*i +: 3]   = op;
      bus.req_a[OPW*i +: OPW]    = a;
      bus.req_b[OPW*i +: OPW]    = b;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      sbq.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic drain(string tag);
      for (int k = 0; k < 40 && sbq.size() > 0; k++) tick();
      check({tag, "_drain"}, 64'(sbq.size()), 64'd0);
      repeat (2) tick();
      check({tag, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_rsp_v"}, 64'(bus.rsp_valid), 64'd0);
      check({tag, "_rsp_d"}, 64'(bus.rsp_data), 64'd0);
      check({tag, "_rsp_e"}, 64'(bus.rsp_err), 64'd0);
      check({tag, "_op"}, 64'(bus.alu_opcode), 64'd0);
      check({tag, "_a"}, 64'(bus.alu_a), 64'd0);
      check({tag, "_b"}, 64'(bus.alu_b), 64'd0);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_rdy"}, 64'(bus.req_ready), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1);
   end

   int pat [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
   logic [2:0] ops [5] = '{3'b001, 3'b011, 3'b011, 3'b010, 3'b111};

   initial begin
      idle();
      repeat (2) tick();
      check_zero("reset");
      rst_n = 1'b1;

      // single MUL from requester 0
      set_req(0, 3'b001, 37'd3, 37'd5);
      @(negedge clk);
      check("single_rdy", 64'(bus.req_ready), 64'b0001);
      tick();
      idle();
      check("single_op", 64'(bus.alu_opcode), 64'b001);
      check("single_a", 64'(bus.alu_a), 64'd3);
      check("single_b", 64'(bus.alu_b), 64'd5);
      check("single_busy", 64'(bus.busy), 64'd1);
      drain("single");

      // all four contend every cycle
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 3'b011, OPW'(i), 37'd10);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("rr%0d", k), 64'(bus.req_ready),
               64'(1) << (k % 4));
         tick();
      end
      idle();
      drain("contend");

      // credit limit on requester 1
      do_reset();
      set_req(1, 3'b001, 37'd2, 37'd7);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check($sformatf("credit%0d", k), 64'(bus.req_ready[1]),
               64'(pat[k]));
         tick();
      end
      idle();
      drain("credit");

      // legal op then illegal op: operands must clear
      do_reset();
      set_req(0, 3'b011, 37'd100, 37'd1);
      tick();
      idle();
      set_req(2, 3'b010, 37'd9, 37'd9);
      @(negedge clk);
      check("ill_rdy", 64'(bus.req_ready), 64'b0100);
      tick();
      idle();
      check("ill_op", 64'(bus.alu_opcode), 64'd0);
      check("ill_a", 64'(bus.alu_a), 64'd0);
      check("ill_b", 64'(bus.alu_b), 64'd0);
      check("ill_busy", 64'(bus.busy), 64'd1);
      drain("illegal");

      // random traffic
      do_reset();
      for (int k = 0; k < 40; k++) begin
         idle();
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 1) == 1)
               set_req(i, ops[$urandom_range(0, 4)],
                       OPW'({$urandom(), $urandom()}),
                       OPW'({$urandom(), $urandom()}));
         end
         tick();
      end
      idle();
      drain("random");

      // reset with three operations in flight
      do_reset();
      for (int i = 0; i < 3; i++)
         set_req(i, 3'b011, OPW'(i + 1), 37'd1);
      repeat (3) tick();
      idle();
      rst_n = 1'b0;
      sbq.delete();
      #1;
      check_zero("midrst");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      check("midrst_busy", 64'(bus.busy), 64'd0);
      set_req(1, 3'b011, 37'd4, 37'd4);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("midrst_cr%0d", k),
               64'(bus.req_ready[1]), 64'd1);
         tick();
      end
      idle();
      drain("midrst");

`ifdef IALU_ARB_PERF_EN
      // 4 issues + 4 stalls, then 6 stall-free issues
      do_reset();
      set_req(0, 3'b011, 37'd5, 37'd6);
      repeat (8) tick();
      idle();
      for (int i = 1; i < NREQ; i++)
         set_req(i, 3'b011, OPW'(i), OPW'(i));
      repeat (6) tick();
      idle();
      drain("perf");
      check("perf_issue", 64'(perf_issue), 64'd10);
      check("perf_stall", 64'(perf_stall), 64'd4);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ialu_issue_arb.md
Name: ialu_issue_arb

Overview:
Round-robin issue arbiter and result router that shares one pipelined integer ALU between NREQ requesters, such as FIR tap engines. Each cycle it accepts at most one operation and registers it into the ALU inputs. It tracks each operation's requester through a tag pipeline matched to the ALU latency and returns the result to the owning requester. Per-requester credit counters bound the number of outstanding operations, because the response path has no backpressure.

Parameters:
DWIDTH, 16, ALU base data width
NREQ, 4, number of requesters (2..8)
LAT, 4, ALU latency in cycles: alu_y is valid LAT cycles after alu_* are driven
MAX_OUT, 2, maximum in-flight operations per requester (1..7)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; combinational, one-hot or zero
req_opcode  in  3*NREQ  flattened opcodes, requester i at [3i+2:3i]
req_a  in  (2*DWIDTH+5)*NREQ  flattened operand A
req_b  in  (2*DWIDTH+5)*NREQ  flattened operand B
alu_opcode  out  3  registered ALU opcode
alu_a  out  2*DWIDTH+5  registered ALU operand A
alu_b  out  2*DWIDTH+5  registered ALU operand B
alu_y  in  2*DWIDTH+6  ALU result
rsp_valid  out  NREQ  registered one-hot result strobe
rsp_data  out  2*DWIDTH+6  registered result
rsp_err  out  1  registered flag: the response is for an illegal opcode
busy  out  1  high while any operation is in flight

Behaviour:
- Reset values: all outputs 0, alu_opcode = OP_NOP, RR pointer = 0, tag pipeline empty, credit counters 0. Reset asserted mid-operation discards all in-flight operations; no response is ever produced for them.
- Eligibility: requester i is eligible when req_valid[i] and cnt[i] < MAX_OUT.
- Arbitration:
  - Round-robin starting at the pointer; the first eligible requester gets req_ready[i]=1.
  - The pointer moves to (winner+1) mod NREQ only on an accepted handshake.
  - With no eligible requester, the pointer holds and no request is accepted.
- Issue (on the handshake edge):
  - Legal opcodes are OP_MUL=3'b001 and OP_ADD=3'b011. For a legal opcode, alu_opcode/alu_a/alu_b load the request.
  - For an illegal opcode, the request is still accepted, alu_opcode loads OP_NOP and alu_a/alu_b load 0.
  - With no handshake, alu_opcode loads OP_NOP and the operands hold their previous values.
- Tag pipeline: LAT+1 stages of {valid, id, err}. Stage 0 loads together with the alu_* registers; the last stage aligns with alu_y.
- Response: when the last tag stage is valid, on the next edge:
  - rsp_valid = onehot(id);
  - rsp_data = err ? 0 : alu_y;
  - rsp_err = err.
  Otherwise rsp_valid = 0, and rsp_data/rsp_err hold.
- Latency: a handshake in cycle 0 gives rsp_valid in cycle LAT+2 (6 by default). Throughput is one operation per cycle.
- Credits:
  - cnt[i] increments on an accepted handshake and decrements when rsp_valid[i] is set.
  - Both in the same cycle: cnt unchanged.
  - cnt never exceeds MAX_OUT and never goes below 0.
- busy = OR of all tag-stage valids and alu_opcode != OP_NOP.
- Response order is issue order, both globally and per requester.
- Widths: operands are 2*DWIDTH+5 bits; the result is 2*DWIDTH+6 bits. The block passes data through with no arithmetic.

Optional Feature:
IALU_ARB_PERF_EN
- Defined: adds output ports perf_issue (32b) and perf_stall (32b).
  - perf_issue counts accepted legal operations.
  - perf_stall counts cycles where some req_valid is high but no request is accepted because of credits.
  - Both counters saturate at 2^32-1 and reset to 0.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- ialu_pkg holds:
  - OP_NOP=3'b000, OP_MUL=3'b001, OP_ADD=3'b011;
  - an is_legal_op function;
  - opw(DWIDTH)=2*DWIDTH+5 and resw(DWIDTH)=2*DWIDTH+6;
  - a clog2 helper for the id width.
- One sub-module, rr_arbiter: inputs are NREQ eligibility bits and an advance strobe; outputs are the one-hot grant and the pointer.
- The credit counters and tag pipeline stay in the top module.

Test Plan:
- Single request: req0 MUL, a=3, b=5, others idle → rsp_valid=4'b0001 in cycle 6, rsp_data=15, rsp_err=0, cnt0 back to 0.
- Contention: all 4 request ADD a=i, b=10 every cycle → grants in order 0,1,2,3,0…; responses arrive in the same order with data 10+i, one per cycle.
- Credit limit: req1 held valid, MAX_OUT=2 → accepted in cycles 0 and 1, req_ready[1]=0 in cycles 2–5; accepted again in cycle 6, when the first response retires.
- Illegal opcode: req2 opcode 3'b010 → accepted, alu_opcode=OP_NOP, rsp_valid[2] in cycle 6 with rsp_err=1 and rsp_data=0.
- Reset mid-flight: issue 3 operations, assert rst_n=0 in cycle 3 → all outputs 0 immediately; no rsp_valid after release; counters 0 and busy=0.
- Perf (macro defined): 10 legal issues plus 4 credit-stalled cycles → perf_issue=10, perf_stall=4.
